// File: rtl/pi1_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pi1_arbiter_pkg
// Shared definitions for the pi1 round-robin arbiter:
//   - pi1 op encodings (PINOOP/PIWROP/PIRDOP/PIRWOP)
//   - arbiter FSM state constants
//   - clog2 helper for elaboration-time width derivation
// ---------------------------------------------------------------------------
package pi1_arbiter_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pi1_rrpick.sv
// ---------------------------------------------------------------------------
// pi1_rrpick
// Combinational round-robin picker. Chooses the first pending index strictly
// after last_i, wrapping modulo MASTERCOUNT; last_i itself is chosen only when
// it is the sole pending entry.
// Ports:
//   pending_i [MASTERCOUNT] : one bit per requester
//   last_i    [IDXBITSZ]    : index granted most recently
//   idx_o     [IDXBITSZ]    : chosen index (meaningful when valid_o)
//   valid_o                 : at least one pending bit set
// ---------------------------------------------------------------------------
module pi1_rrpick #(
    parameter int MASTERCOUNT = 2,
    parameter int IDXBITSZ    = 1
) (
    input  logic [MASTERCOUNT-1:0] pending_i,
    input  logic [IDXBITSZ-1:0]    last_i,
    output logic [IDXBITSZ-1:0]    idx_o,
    output logic                   valid_o
);

    logic [IDXBITSZ-1:0]      start;
    logic [2*MASTERCOUNT-1:0] doubled;
    logic [MASTERCOUNT-1:0]   rotated;
    logic [IDXBITSZ-1:0]      offset;
    logic [IDXBITSZ:0]        sum;

    always_comb begin
        // Search begins one past last_i; explicit wrap so non-power-of-2
        // counts behave.
        if (last_i == IDXBITSZ'(MASTERCOUNT - 1)) begin
            start = '0;
        end else begin
            start = last_i + IDXBITSZ'(1);
        end

        // Rotate so bit 0 of 'rotated' is the highest-priority candidate.
        doubled = {pending_i, pending_i};
        rotated = MASTERCOUNT'(doubled >> start);

        // Priority encode: lowest set bit wins (loop runs downward so the
        // last assignment is the lowest index).
        offset  = '0;
        valid_o = 1'b0;
        for (int i = MASTERCOUNT - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset  = IDXBITSZ'(i);
                valid_o = 1'b1;
            end
        end

        // Undo the rotation.
        sum = {1'b0, start} + {1'b0, offset};
        if (sum >= (IDXBITSZ + 1)'(MASTERCOUNT)) begin
            sum = sum - (IDXBITSZ + 1)'(MASTERCOUNT);
        end
        idx_o = sum[IDXBITSZ-1:0];
    end

endmodule

// File: rtl/pi1_arbiter.sv
// ---------------------------------------------------------------------------
// pi1_arbiter
// Round-robin arbiter sharing one pi1 slave port among MASTERCOUNT masters.
// Requests are queued by keeping each accepted master stalled (m_rdy_o low)
// and are issued to the slave one at a time.
//
// Handshake semantics (both sides):
//   master m : request accepted on an edge with m_op_i[m]!=PINOOP and
//              m_rdy_o[m]==1; m_rdy_o[m] then stays low until completion,
//              and rises together with valid m_data_o. The master holds
//              op/addr/data/sel stable while m_rdy_o[m] is low.
//   slave    : op accepted on an edge with s_op_o!=PINOOP and s_rdy_i==1;
//              completion is the next later edge with s_rdy_i==1, where
//              s_data_i is captured.
//
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   m_op_i/m_addr_i/m_data_i/m_sel_i : packed per-master request fields
//   m_data_o, m_rdy_o  : shared read data, per-master ready
//   s_op_o/s_addr_o/s_data_o/s_sel_o : request to slave (registered)
//   s_data_i, s_rdy_i  : slave response
//   dbg_state_o        : FSM state (IDLE/ISSUE/WAIT)
// ---------------------------------------------------------------------------
module pi1_arbiter
    import pi1_arbiter_pkg::*;
#(
    parameter  int ARCHBITSZ   = 16,
    parameter  int MASTERCOUNT = 2,
    localparam int SELBITSZ    = ARCHBITSZ / 8,
    localparam int ADDRBITSZ   = ARCHBITSZ - clog2(SELBITSZ),
    localparam int IDXBITSZ    = (MASTERCOUNT > 1) ? clog2(MASTERCOUNT) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [2*MASTERCOUNT-1:0]        m_op_i,
    input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i,
    input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i,
    input  logic [SELBITSZ*MASTERCOUNT-1:0] m_sel_i,
    output logic [ARCHBITSZ-1:0]            m_data_o,
    output logic [MASTERCOUNT-1:0]          m_rdy_o,
    output logic [1:0]                      s_op_o,
    output logic [ADDRBITSZ-1:0]            s_addr_o,
    output logic [ARCHBITSZ-1:0]            s_data_o,
    input  logic [ARCHBITSZ-1:0]            s_data_i,
    output logic [SELBITSZ-1:0]             s_sel_o,
    input  logic                            s_rdy_i,
    output logic [1:0]                      dbg_state_o
);

    logic [1:0]             state_q, state_d;
    logic [IDXBITSZ-1:0]    g_q, g_d;
    logic [IDXBITSZ-1:0]    last_q, last_d;
    logic [MASTERCOUNT-1:0] m_rdy_q, m_rdy_d;
    logic [ARCHBITSZ-1:0]   m_data_q, m_data_d;
    logic [1:0]             s_op_q, s_op_d;
    logic [ADDRBITSZ-1:0]   s_addr_q, s_addr_d;
    logic [ARCHBITSZ-1:0]   s_data_q, s_data_d;
    logic [SELBITSZ-1:0]    s_sel_q, s_sel_d;

    logic [MASTERCOUNT-1:0] pending;
    logic [IDXBITSZ-1:0]    pick_idx;
    logic                   pick_valid;

    // A master is pending exactly while it is stalled.
    assign pending = ~m_rdy_q;

    pi1_rrpick #(
        .MASTERCOUNT (MASTERCOUNT),
        .IDXBITSZ    (IDXBITSZ)
    ) u_rrpick (
        .pending_i (pending),
        .last_i    (last_q),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        last_d   = last_q;
        m_rdy_d  = m_rdy_q;
        m_data_d = m_data_q;
        s_op_d   = s_op_q;
        s_addr_d = s_addr_q;
        s_data_d = s_data_q;
        s_sel_d  = s_sel_q;

        // Accept new requests from every idle master, independent of FSM.
        for (int m = 0; m < MASTERCOUNT; m++) begin
            if (m_rdy_q[m] && (m_op_i[2*m +: 2] != PINOOP)) begin
                m_rdy_d[m] = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    g_d      = pick_idx;
                    s_op_d   = m_op_i[2*int'(pick_idx) +: 2];
                    s_addr_d = m_addr_i[ADDRBITSZ*int'(pick_idx) +: ADDRBITSZ];
                    s_data_d = m_data_i[ARCHBITSZ*int'(pick_idx) +: ARCHBITSZ];
                    s_sel_d  = m_sel_i[SELBITSZ*int'(pick_idx) +: SELBITSZ];
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (s_rdy_i) begin
                    s_op_d  = PINOOP;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (s_rdy_i) begin
                    m_data_d   = s_data_i;
                    m_rdy_d[g_q] = 1'b1;
                    last_d     = g_q;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            g_q      <= '0;
            // Master 0 wins the first arbitration after reset.
            last_q   <= IDXBITSZ'(MASTERCOUNT - 1);
            m_rdy_q  <= '1;
            m_data_q <= '0;
            s_op_q   <= PINOOP;
            s_addr_q <= '0;
            s_data_q <= '0;
            s_sel_q  <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            last_q   <= last_d;
            m_rdy_q  <= m_rdy_d;
            m_data_q <= m_data_d;
            s_op_q   <= s_op_d;
            s_addr_q <= s_addr_d;
            s_data_q <= s_data_d;
            s_sel_q  <= s_sel_d;
        end
    end

    assign m_data_o    = m_data_q;
    assign m_rdy_o     = m_rdy_q;
    assign s_op_o      = s_op_q;
    assign s_addr_o    = s_addr_q;
    assign s_data_o    = s_data_q;
    assign s_sel_o     = s_sel_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pi1_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pi1_arbiter
// Self-checking bench for pi1_arbiter with ARCHBITSZ=16, MASTERCOUNT=3.
// Single-transaction vectors come from a table; round-robin order, stalls
// and reset-mid-transaction are hand-written sequences. Slave-side write
// data and master completion order are checked through expected queues.
// ---------------------------------------------------------------------------
module tb_pi1_arbiter;
    import pi1_arbiter_pkg::*;

    localparam int MC = 3;
    localparam int DW = 16;
    localparam int AW = 15;
    localparam int SW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [2*MC-1:0]  m_op_i;
    logic [AW*MC-1:0] m_addr_i;
    logic [DW*MC-1:0] m_data_i;
    logic [SW*MC-1:0] m_sel_i;
    logic [DW-1:0]    m_data_o;
    logic [MC-1:0]    m_rdy_o;
    logic [1:0]       s_op_o;
    logic [AW-1:0]    s_addr_o;
    logic [DW-1:0]    s_data_o;
    logic [DW-1:0]    s_data_i;
    logic [SW-1:0]    s_sel_o;
    logic             s_rdy_i;
    logic [1:0]       dbg_state_o;

    pi1_arbiter #(.ARCHBITSZ(DW), .MASTERCOUNT(MC)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .m_op_i      (m_op_i),
        .m_addr_i    (m_addr_i),
        .m_data_i    (m_data_i),
        .m_sel_i     (m_sel_i),
        .m_data_o    (m_data_o),
        .m_rdy_o     (m_rdy_o),
        .s_op_o      (s_op_o),
        .s_addr_o    (s_addr_o),
        .s_data_o    (s_data_o),
        .s_data_i    (s_data_i),
        .s_sel_o     (s_sel_o),
        .s_rdy_i     (s_rdy_i),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- per-master drive state ----------------
    logic [1:0]    mop   [MC];
    logic [AW-1:0] maddr [MC];
    logic [DW-1:0] mdata [MC];
    logic [SW-1:0] msel  [MC];
    int            req_left [MC];
    int            done_cyc [MC];
    logic [MC-1:0] prev_rdy;

    always_comb begin
        m_op_i   = '0;
        m_addr_i = '0;
        m_data_i = '0;
        m_sel_i  = '0;
        for (int m = 0; m < MC; m++) begin
            m_op_i[2*m +: 2]    = mop[m];
            m_addr_i[AW*m +: AW] = maddr[m];
            m_data_i[DW*m +: DW] = mdata[m];
            m_sel_i[SW*m +: SW]  = msel[m];
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];      // expected s_data_o at each slave accept
    int            exp_done_q[$]; // expected master order of completions
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        logic          acc;
        logic [DW-1:0] acc_data;
        acc      = (s_op_o != PINOOP) && s_rdy_i && !rst_i;
        acc_data = s_data_o;
        @(posedge clk);
        #1;
        cyc++;
        if (acc === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL slave_accept_unexpected: got data 0x%0h expected no accept", acc_data);
            end else begin
                chk("slave_accept_data", acc_data, exp_q.pop_front());
            end
        end
        for (int m = 0; m < MC; m++) begin
            if (req_left[m] > 0 && m_rdy_o[m] === 1'b1 && prev_rdy[m] === 1'b0) begin
                if (exp_done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL completion_unexpected: got master %0d expected none", m);
                end else begin
                    chk("completion_order", m, exp_done_q.pop_front());
                end
                done_cyc[m]   = cyc;
                last_done_cyc = cyc;
                req_left[m]--;
                if (req_left[m] == 0) mop[m] = PINOOP;
            end
        end
        prev_rdy = m_rdy_o;
    endtask

    task automatic request(input int m, input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [SW-1:0] sel, input int count);
        mop[m]      = op;
        maddr[m]    = addr;
        mdata[m]    = data;
        msel[m]     = sel;
        req_left[m] = count;
    endtask

    task automatic run_until_done(input string name, input int budget);
        for (int i = 0; i < budget && exp_done_q.size() != 0; i++) step();
        chk(name, exp_done_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int            m;
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] sel;
        logic [DW-1:0] rdata;
        logic [1:0]    e_op;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic [SW-1:0] e_sel;
        logic [DW-1:0] e_mdata;
    } vec_t;

    vec_t vecs[3];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;

        vecs[0] = '{m:0, op:PIRDOP, addr:15'h0012, wdata:16'h0000, sel:2'b11, rdata:16'hBEEF,
                    e_op:2'b10, e_addr:15'h0012, e_data:16'h0000, e_sel:2'b11, e_mdata:16'hBEEF};
        vecs[1] = '{m:1, op:PIRWOP, addr:15'h0345, wdata:16'h1234, sel:2'b10, rdata:16'hCAFE,
                    e_op:2'b11, e_addr:15'h0345, e_data:16'h1234, e_sel:2'b10, e_mdata:16'hCAFE};
        vecs[2] = '{m:2, op:PIWROP, addr:15'h7FFF, wdata:16'hFFFF, sel:2'b01, rdata:16'h0001,
                    e_op:2'b01, e_addr:15'h7FFF, e_data:16'hFFFF, e_sel:2'b01, e_mdata:16'h0001};

        for (int m = 0; m < MC; m++) begin
            request(m, PINOOP, '0, '0, '0, 0);
            done_cyc[m] = 0;
        end
        prev_rdy = '1;
        s_rdy_i  = 1'b1;
        s_data_i = '0;

        // ---- reset ----
        rst_i = 1'b1;
        step();
        step();
        chk("rst_m_rdy", m_rdy_o, 3'b111);
        chk("rst_m_data", m_data_o, 16'h0000);
        chk("rst_s_op", s_op_o, PINOOP);
        chk("rst_s_addr", s_addr_o, 15'h0000);
        chk("rst_s_data", s_data_o, 16'h0000);
        chk("rst_s_sel", s_sel_o, 2'b00);
        chk("rst_state", dbg_state_o, ST_IDLE);
        rst_i = 1'b0;
        step();

        // ---- table: single transactions, zero-wait slave ----
        for (int v = 0; v < 3; v++) begin
            s_rdy_i  = 1'b1;
            s_data_i = vecs[v].rdata;
            chk($sformatf("v%0d_pre_rdy", v), m_rdy_o[vecs[v].m], 1'b1);
            request(vecs[v].m, vecs[v].op, vecs[v].addr, vecs[v].wdata, vecs[v].sel, 1);
            exp_q.push_back(vecs[v].e_data);
            exp_done_q.push_back(vecs[v].m);
            step(); // T0
            chk($sformatf("v%0d_t0_rdy", v), m_rdy_o[vecs[v].m], 1'b0);
            chk($sformatf("v%0d_t0_state", v), dbg_state_o, ST_IDLE);
            step(); // T1
            chk($sformatf("v%0d_t1_state", v), dbg_state_o, ST_ISSUE);
            chk($sformatf("v%0d_s_op", v), s_op_o, vecs[v].e_op);
            chk($sformatf("v%0d_s_addr", v), s_addr_o, vecs[v].e_addr);
            chk($sformatf("v%0d_s_data", v), s_data_o, vecs[v].e_data);
            chk($sformatf("v%0d_s_sel", v), s_sel_o, vecs[v].e_sel);
            step(); // T2
            chk($sformatf("v%0d_t2_state", v), dbg_state_o, ST_WAIT);
            chk($sformatf("v%0d_t2_s_op", v), s_op_o, PINOOP);
            chk($sformatf("v%0d_t2_rdy", v), m_rdy_o[vecs[v].m], 1'b0);
            step(); // T3
            chk($sformatf("v%0d_t3_rdy", v), m_rdy_o[vecs[v].m], 1'b1);
            chk($sformatf("v%0d_m_data", v), m_data_o, vecs[v].e_mdata);
            chk($sformatf("v%0d_t3_state", v), dbg_state_o, ST_IDLE);
        end
        chk("table_done_q", exp_done_q.size(), 0);

        // ---- all three masters requesting twice: order 0,1,2,0,1,2 ----
        s_rdy_i  = 1'b1;
        s_data_i = 16'h0055;
        for (int m = 0; m < MC; m++) request(m, PIWROP, AW'(16'h0100 + m), DW'(16'hA000 + m), 2'b11, 2);
        for (int r = 0; r < 2; r++) begin
            for (int m = 0; m < MC; m++) begin
                exp_q.push_back(DW'(16'hA000 + m));
                exp_done_q.push_back(m);
            end
        end
        c0 = cyc;
        run_until_done("rr_timeout", 60);
        chk("rr_total_cycles", last_done_cyc - c0, 19);

        // ---- masters 0,1 in the same edge ----
        s_data_i = 16'h0F0F;
        request(0, PIWROP, 15'h0200, 16'h1111, 2'b11, 1);
        request(1, PIWROP, 15'h0201, 16'h2222, 2'b11, 1);
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        exp_done_q.push_back(0);
        exp_done_q.push_back(1);
        c0 = cyc;
        run_until_done("dual_timeout", 30);
        chk("dual_m0_latency", done_cyc[0] - c0, 4);
        chk("dual_m1_after_m0", done_cyc[1] - done_cyc[0], 3);

        // ---- slave stalls: 4 cycles in ISSUE, 5 in WAIT ----
        s_rdy_i  = 1'b0;
        s_data_i = 16'h7777;
        request(1, PIRDOP, 15'h0ABC, 16'h5A5A, 2'b11, 1);
        exp_q.push_back(16'h5A5A);
        exp_done_q.push_back(1);
        c0 = cyc;
        step(); // T0
        chk("stall_t0_rdy", m_rdy_o, 3'b101);
        step(); // T1
        chk("stall_t1_state", dbg_state_o, ST_ISSUE);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_issue_state", dbg_state_o, ST_ISSUE);
            chk("stall_issue_s_op", s_op_o, PIRDOP);
            chk("stall_issue_s_addr", s_addr_o, 15'h0ABC);
            chk("stall_issue_s_data", s_data_o, 16'h5A5A);
            chk("stall_issue_s_sel", s_sel_o, 2'b11);
            chk("stall_issue_rdy", m_rdy_o, 3'b101);
        end
        s_rdy_i = 1'b1;
        step(); // slave accept
        chk("stall_accept_state", dbg_state_o, ST_WAIT);
        s_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_wait_state", dbg_state_o, ST_WAIT);
            chk("stall_wait_rdy", m_rdy_o, 3'b101);
            chk("stall_wait_m_data_hold", m_data_o, 16'h0F0F);
            chk("stall_wait_s_addr", s_addr_o, 15'h0ABC);
        end
        s_rdy_i = 1'b1;
        step(); // completion
        chk("stall_done_rdy", m_rdy_o, 3'b111);
        chk("stall_done_m_data", m_data_o, 16'h7777);
        chk("stall_latency", cyc - c0, 13);

        // ---- reset during WAIT with masters 0,2 pending ----
        s_rdy_i = 1'b1;
        request(0, PIRDOP, 15'h0010, 16'h0000, 2'b11, 1);
        request(2, PIWROP, 15'h0020, 16'h2020, 2'b11, 1);
        exp_q.push_back(16'h2020);
        step(); // T0
        chk("rst_wait_t0_rdy", m_rdy_o, 3'b010);
        step(); // T1: master 1 was last, so master 2 is next
        chk("rst_wait_t1_state", dbg_state_o, ST_ISSUE);
        chk("rst_wait_t1_addr", s_addr_o, 15'h0020);
        step(); // T2
        chk("rst_wait_t2_state", dbg_state_o, ST_WAIT);
        s_rdy_i = 1'b0;
        for (int m = 0; m < MC; m++) request(m, PINOOP, '0, '0, '0, 0);
        rst_i = 1'b1;
        step();
        chk("rst_wait_rdy", m_rdy_o, 3'b111);
        chk("rst_wait_s_op", s_op_o, PINOOP);
        chk("rst_wait_state", dbg_state_o, ST_IDLE);
        chk("rst_wait_m_data", m_data_o, 16'h0000);
        rst_i = 1'b0;
        s_rdy_i  = 1'b1;
        s_data_i = 16'h4242;
        request(2, PIRDOP, 15'h0033, 16'h0000, 2'b11, 1);
        exp_q.push_back(16'h0000);
        exp_done_q.push_back(2);
        step(); // T0
        step(); // T1
        chk("post_rst_state", dbg_state_o, ST_ISSUE);
        chk("post_rst_s_addr", s_addr_o, 15'h0033);
        step();
        step();
        chk("post_rst_rdy", m_rdy_o, 3'b111);
        chk("post_rst_m_data", m_data_o, 16'h4242);

        // ---- drain ----
        chk("exp_q_drained", exp_q.size(), 0);
        chk("done_q_drained", exp_done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
